sipo_deserializer: RTL and testbench

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

---
 rtl/sipo_deserializer.sv | 163 ++++++++++++++++
 tb/tb_sipo_deserializer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with a start-of-frame marker and a
// ready/valid handoff to a downstream parallel register.
//
// Parameters:
//   WIDTH      parallel word width (2..32)
//   MSB_FIRST  1: first serial bit lands in par_out[WIDTH-1]; 0: in par_out[0]
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   sin, sin_valid   serial data bit and its sample strobe
//   sof              start of frame (qualified by sin_valid)
//   par_ready        downstream accepts par_out
//   clr_err          synchronous clear of the sticky error flags
//   par_out          last completed word
//   par_valid        par_out holds a word not yet accepted
//   busy             a frame is being collected
//   overrun          sticky: a valid bit was dropped while holding a word
//   frame_err        sticky: a frame was restarted before it completed
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sof,
    input  logic             par_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t           r_state,     w_state_nxt;
    logic [CW-1:0]    r_count,     w_count_nxt;
    logic [WIDTH-1:0] r_shift,     w_shift_nxt;
    logic [WIDTH-1:0] r_par_out,   w_par_out_nxt;
    logic             r_par_valid, w_par_valid_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_overrun,   w_overrun_nxt;
    logic             r_frame_err, w_frame_err_nxt;

    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_shifted;
    logic             w_last;
    logic             w_start;

    // Frame image for the first bit of a frame and for appending one more bit.
    // Either way, after WIDTH bits the first bit sits at the chosen end.
    always_comb begin
        w_first = '0;
        if (MSB_FIRST) begin
            w_first[0] = sin;
            w_shifted  = {r_shift[WIDTH-2:0], sin};
        end else begin
            w_first[WIDTH-1] = sin;
            w_shifted        = {sin, r_shift[WIDTH-1:1]};
        end
    end

    assign w_last  = (r_count == CW'(WIDTH - 1));
    assign w_start = sin_valid && sof;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_shift     <= '0;
            r_par_out   <= '0;
            r_par_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_shift     <= w_shift_nxt;
            r_par_out   <= w_par_out_nxt;
            r_par_valid <= w_par_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_overrun   <= w_overrun_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Next-state and output logic; sticky flags set after clear so set wins.
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_shift_nxt     = r_shift;
        w_par_out_nxt   = r_par_out;
        w_par_valid_nxt = r_par_valid;
        w_overrun_nxt   = r_overrun   && !clr_err;
        w_frame_err_nxt = r_frame_err && !clr_err;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_shift_nxt = w_first;
                    w_count_nxt = CW'(1);
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (sin_valid) begin
                    if (sof) begin
                        w_shift_nxt     = w_first;
                        w_count_nxt     = CW'(1);
                        w_frame_err_nxt = 1'b1;
                    end else if (w_last) begin
                        w_shift_nxt     = w_shifted;
                        w_par_out_nxt   = w_shifted;
                        w_par_valid_nxt = 1'b1;
                        w_count_nxt     = '0;
                        w_state_nxt     = ST_HOLD;
                    end else begin
                        w_shift_nxt = w_shifted;
                        w_count_nxt = r_count + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (r_par_valid && par_ready) begin
                    // Handshake edge: a sof bit here opens the next frame at once.
                    w_par_valid_nxt = 1'b0;
                    w_count_nxt     = '0;
                    w_state_nxt     = ST_IDLE;
                    if (w_start) begin
                        w_shift_nxt = w_first;
                        w_count_nxt = CW'(1);
                        w_state_nxt = ST_COLLECT;
                    end
                end else if (sin_valid) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_COLLECT);
    end

    assign par_out   = r_par_out;
    assign par_valid = r_par_valid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: one MSB-first and one LSB-first instance share
// the same stimulus; a frame-level model predicts both on every cycle.
module tb_sipo_deserializer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sin, sin_valid, sof, par_ready, clr_err;
    logic [W-1:0] m_par_out, l_par_out;
    logic         m_par_valid, l_par_valid;
    logic         m_busy, l_busy;
    logic         m_overrun, l_overrun;
    logic         m_frame_err, l_frame_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .par_ready(par_ready), .clr_err(clr_err), .par_out(m_par_out),
        .par_valid(m_par_valid), .busy(m_busy), .overrun(m_overrun),
        .frame_err(m_frame_err)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .par_ready(par_ready), .clr_err(clr_err), .par_out(l_par_out),
        .par_valid(l_par_valid), .busy(l_busy), .overrun(l_overrun),
        .frame_err(l_frame_err)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 waiting for sof, 1 gathering bits, 2 word waiting for pickup
    int           md_mode;
    bit           md_q[$];
    logic [W-1:0] md_word_msb, md_word_lsb;
    bit           md_ovr, md_ferr, md_set_ovr, md_set_ferr;

    function automatic logic [W-1:0] pack_word(input bit msb_first);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (msb_first) w[W-1-i] = md_q[i];
            else           w[i]     = md_q[i];
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_mode     = 0;
            md_q.delete();
            md_word_msb = '0;
            md_word_lsb = '0;
            md_ovr      = 1'b0;
            md_ferr     = 1'b0;
        end else begin
            md_set_ovr  = 1'b0;
            md_set_ferr = 1'b0;
            if (md_mode == 0) begin
                if (sin_valid && sof) begin
                    md_q.delete(); md_q.push_back(sin); md_mode = 1;
                end
            end else if (md_mode == 1) begin
                if (sin_valid && sof) begin
                    md_q.delete(); md_q.push_back(sin); md_set_ferr = 1'b1;
                end else if (sin_valid) begin
                    md_q.push_back(sin);
                    if (md_q.size() == int'(W)) begin
                        md_word_msb = pack_word(1'b1);
                        md_word_lsb = pack_word(1'b0);
                        md_mode     = 2;
                    end
                end
            end else begin
                if (par_ready) begin
                    md_mode = 0;
                    if (sin_valid && sof) begin
                        md_q.delete(); md_q.push_back(sin); md_mode = 1;
                    end
                end else if (sin_valid) begin
                    md_set_ovr = 1'b1;
                end
            end
            md_ovr  = (md_ovr  && !clr_err) || md_set_ovr;
            md_ferr = (md_ferr && !clr_err) || md_set_ferr;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("msb par_out",   32'(m_par_out),   32'(md_word_msb));
        check("lsb par_out",   32'(l_par_out),   32'(md_word_lsb));
        check("msb par_valid", 32'(m_par_valid), 32'(md_mode == 2));
        check("lsb par_valid", 32'(l_par_valid), 32'(md_mode == 2));
        check("msb busy",      32'(m_busy),      32'(md_mode == 1));
        check("lsb busy",      32'(l_busy),      32'(md_mode == 1));
        check("overrun",       32'(m_overrun),   32'(md_ovr));
        check("frame_err",     32'(m_frame_err), 32'(md_ferr));
        check("lsb overrun",   32'(l_overrun),   32'(md_ovr));
        check("lsb frame_err", 32'(l_frame_err), 32'(md_ferr));
    end

    // One sample edge with the given serial inputs; returns at the next negedge.
    task automatic drive(input logic v, input logic s, input logic b);
        sin_valid = v; sof = s; sin = b;
        @(negedge clk);
    endtask

    int busy_cnt, pv_cnt;

    initial begin
        rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0;
        par_ready = 1'b1; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset par_out", 32'(m_par_out), 32'h0);
        check("reset busy",    32'(m_busy),    32'h0);
        rst_n = 1'b1;

        // Non-sof bits while idle are ignored.
        drive(1, 0, 1); drive(1, 0, 0);
        check("idle ignore busy", 32'(m_busy), 32'h0);
        check("idle ignore ferr", 32'(m_frame_err), 32'h0);

        // Basic frame 1,0,1,1 with par_ready high.
        busy_cnt = 0; pv_cnt = 0;
        drive(1, 1, 1); busy_cnt += int'(m_busy); pv_cnt += int'(m_par_valid);
        drive(1, 0, 0); busy_cnt += int'(m_busy); pv_cnt += int'(m_par_valid);
        drive(1, 0, 1); busy_cnt += int'(m_busy); pv_cnt += int'(m_par_valid);
        drive(1, 0, 1); busy_cnt += int'(m_busy); pv_cnt += int'(m_par_valid);
        check("frame1 msb word", 32'(m_par_out), 32'b1011);
        check("frame1 lsb word", 32'(l_par_out), 32'b1101);
        check("frame1 pv",       32'(m_par_valid), 32'h1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0); busy_cnt += int'(m_busy); pv_cnt += int'(m_par_valid);
        end
        check("frame1 busy cycles", 32'(busy_cnt), 32'd3);
        check("frame1 pv cycles",   32'(pv_cnt),   32'd1);
        check("frame1 hold word",   32'(m_par_out), 32'b1011);

        // Overrun while holding 4'hA.
        par_ready = 1'b0;
        drive(1, 1, 1); drive(1, 0, 0); drive(1, 0, 1); drive(1, 0, 0);
        check("ovr msb word", 32'(m_par_out), 32'hA);
        check("ovr lsb word", 32'(l_par_out), 32'h5);
        check("ovr none yet", 32'(m_overrun), 32'h0);
        drive(1, 0, 1); drive(1, 0, 1);
        check("ovr flag",     32'(m_overrun), 32'h1);
        check("ovr word kept", 32'(m_par_out), 32'hA);
        check("ovr pv kept",   32'(m_par_valid), 32'h1);
        par_ready = 1'b1;
        drive(0, 0, 0);
        check("ovr pv drop",   32'(m_par_valid), 32'h0);
        check("ovr sticky",    32'(m_overrun), 32'h1);
        clr_err = 1'b1; drive(0, 0, 0); clr_err = 1'b0;
        check("ovr cleared",   32'(m_overrun), 32'h0);

        // Frame restart: sof,1,1 then sof+0,0,1,1.
        drive(1, 1, 1); drive(1, 0, 1); drive(1, 1, 0);
        check("restart ferr", 32'(m_frame_err), 32'h1);
        drive(1, 0, 0); drive(1, 0, 1); drive(1, 0, 1);
        check("restart msb word", 32'(m_par_out), 32'b0011);
        check("restart lsb word", 32'(l_par_out), 32'b1100);
        drive(0, 0, 0);
        clr_err = 1'b1; drive(0, 0, 0); clr_err = 1'b0;
        check("ferr cleared", 32'(m_frame_err), 32'h0);

        // Back-to-back: next sof lands on the handshake edge.
        pv_cnt = 0;
        drive(1, 1, 1); drive(1, 0, 1); drive(1, 0, 0); drive(1, 0, 0);
        pv_cnt += int'(m_par_valid);
        check("b2b word1", 32'(m_par_out), 32'b1100);
        drive(1, 1, 0);
        check("b2b no gap busy", 32'(m_busy), 32'h1);
        check("b2b pv dropped",  32'(m_par_valid), 32'h0);
        drive(1, 0, 1); drive(1, 0, 1); drive(1, 0, 0);
        pv_cnt += int'(m_par_valid);
        check("b2b word2",   32'(m_par_out), 32'b0110);
        check("b2b pulses",  32'(pv_cnt), 32'd2);
        check("b2b no ovr",  32'(m_overrun), 32'h0);
        drive(0, 0, 0);

        // Asynchronous reset mid-frame.
        drive(1, 1, 1); drive(1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async par_out", 32'(m_par_out), 32'h0);
        check("async busy",    32'(m_busy),    32'h0);
        check("async pv",      32'(m_par_valid), 32'h0);
        @(negedge clk);
        sin_valid = 1'b1; sof = 1'b0; sin = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 1);
        check("post-reset idle", 32'(m_busy), 32'h0);
        drive(1, 1, 0); drive(1, 0, 1); drive(1, 0, 1); drive(1, 0, 1);
        check("post-reset msb word", 32'(m_par_out), 32'b0111);
        check("post-reset lsb word", 32'(l_par_out), 32'b1110);
        drive(0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            par_ready = ($urandom_range(0, 2) != 0);
            clr_err   = ($urandom_range(0, 15) == 0);
            drive(logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 7) == 0),
                  logic'($urandom_range(0, 1)));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
